// File: rtl/adc_sample_avg.sv
// Boxcar averaging decimator: sums 2^LOG2_N ADC samples and presents the floor-average on a valid/ready output.
// Optional per-window min/max outputs are enabled by defining ADC_AVG_MINMAX_EN.
module adc_sample_avg #(
   parameter int unsigned DATA_W = 12,
   parameter int unsigned LOG2_N = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   input  logic              flush,
   output logic [DATA_W-1:0] avg_out,
   output logic              avg_valid,
   input  logic              avg_ready,
   output logic              overrun,
   input  logic              clr_overrun
`ifdef ADC_AVG_MINMAX_EN
   ,
   output logic [DATA_W-1:0] min_out,
   output logic [DATA_W-1:0] max_out
`endif
);

   localparam int unsigned N     = 32'd1 << LOG2_N;
   localparam int unsigned ACC_W = DATA_W + LOG2_N;
   localparam int unsigned CNT_W = LOG2_N + 1;

   typedef enum logic [0:0] {ACCUM = 1'b0, LAST = 1'b1} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [ACC_W-1:0]   r_acc;
   logic [ACC_W-1:0]   w_acc_nxt;
   logic [ACC_W-1:0]   w_sum;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic [DATA_W-1:0]  w_avg_nxt;
   logic               w_valid_nxt;
   logic               w_ovr_nxt;

`ifdef ADC_AVG_MINMAX_EN
   logic [DATA_W-1:0]  r_min;
   logic [DATA_W-1:0]  r_max;
   logic [DATA_W-1:0]  w_min_nxt;
   logic [DATA_W-1:0]  w_max_nxt;
   logic [DATA_W-1:0]  w_min_s;
   logic [DATA_W-1:0]  w_max_s;
   logic [DATA_W-1:0]  w_min_out_nxt;
   logic [DATA_W-1:0]  w_max_out_nxt;
`endif

   // Accumulator is DATA_W+LOG2_N wide, so a full window of max samples cannot wrap.
   assign w_sum     = r_acc + ACC_W'(sample_in);
   assign w_cnt_inc = r_cnt + CNT_W'(1);

`ifdef ADC_AVG_MINMAX_EN
   assign w_min_s = (sample_in < r_min) ? sample_in : r_min;
   assign w_max_s = (sample_in > r_max) ? sample_in : r_max;
`endif

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ACCUM;
         r_acc     <= '0;
         r_cnt     <= '0;
         avg_out   <= '0;
         avg_valid <= 1'b0;
         overrun   <= 1'b0;
`ifdef ADC_AVG_MINMAX_EN
         r_min     <= '1;
         r_max     <= '0;
         min_out   <= '0;
         max_out   <= '0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_acc     <= w_acc_nxt;
         r_cnt     <= w_cnt_nxt;
         avg_out   <= w_avg_nxt;
         avg_valid <= w_valid_nxt;
         overrun   <= w_ovr_nxt;
`ifdef ADC_AVG_MINMAX_EN
         r_min     <= w_min_nxt;
         r_max     <= w_max_nxt;
         min_out   <= w_min_out_nxt;
         max_out   <= w_max_out_nxt;
`endif
      end
   end

   // Next-state, accumulation, window completion and output handshake.
   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_avg_nxt   = avg_out;
      w_valid_nxt = avg_valid;
      w_ovr_nxt   = overrun;
`ifdef ADC_AVG_MINMAX_EN
      w_min_nxt     = r_min;
      w_max_nxt     = r_max;
      w_min_out_nxt = min_out;
      w_max_out_nxt = max_out;
`endif

      if (avg_valid && avg_ready) begin
         w_valid_nxt = 1'b0;
      end
      if (clr_overrun) begin
         w_ovr_nxt = 1'b0;
      end

      // flush outranks a coincident sample, which is dropped.
      if (flush) begin
         w_state_nxt = ACCUM;
         w_acc_nxt   = '0;
         w_cnt_nxt   = '0;
`ifdef ADC_AVG_MINMAX_EN
         w_min_nxt   = '1;
         w_max_nxt   = '0;
`endif
      end else if (sample_valid) begin
         case (r_state)
            ACCUM: begin
               w_acc_nxt = w_sum;
               w_cnt_nxt = w_cnt_inc;
`ifdef ADC_AVG_MINMAX_EN
               w_min_nxt = w_min_s;
               w_max_nxt = w_max_s;
`endif
               if (w_cnt_inc == CNT_W'(N - 1)) begin
                  w_state_nxt = LAST;
               end
            end
            LAST: begin
               w_state_nxt = ACCUM;
               w_acc_nxt   = '0;
               w_cnt_nxt   = '0;
               w_avg_nxt   = DATA_W'(w_sum >> LOG2_N);
               w_valid_nxt = 1'b1;
               // Set outranks a simultaneous clr_overrun.
               if (avg_valid && !avg_ready) begin
                  w_ovr_nxt = 1'b1;
               end
`ifdef ADC_AVG_MINMAX_EN
               w_min_out_nxt = w_min_s;
               w_max_out_nxt = w_max_s;
               w_min_nxt     = '1;
               w_max_nxt     = '0;
`endif
            end
            default: begin
               w_state_nxt = ACCUM;
               w_acc_nxt   = '0;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_sample_avg.sv
// Scoreboard bench for adc_sample_avg: stimulus pushes expected window results, a monitor pops on each transfer.
module tb_adc_sample_avg;

   localparam int unsigned DATA_W = 12;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DATA_W-1:0] sample_in = '0;
   logic              sample_valid = 1'b0;
   logic              flush = 1'b0;
   logic [DATA_W-1:0] avg_out;
   logic              avg_valid;
   logic              avg_ready = 1'b1;
   logic              overrun;
   logic              clr_overrun = 1'b0;
`ifdef ADC_AVG_MINMAX_EN
   logic [DATA_W-1:0] min_out;
   logic [DATA_W-1:0] max_out;
`endif

   typedef struct {
      int avg;
      int mn;
      int mx;
   } exp_t;

   exp_t q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   adc_sample_avg #(.DATA_W(DATA_W), .LOG2_N(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .flush        (flush),
      .avg_out      (avg_out),
      .avg_valid    (avg_valid),
      .avg_ready    (avg_ready),
      .overrun      (overrun),
      .clr_overrun  (clr_overrun)
`ifdef ADC_AVG_MINMAX_EN
      ,
      .min_out      (min_out),
      .max_out      (max_out)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   task automatic push(input int a, input int mn, input int mx);
      exp_t e;
      e.avg = a;
      e.mn  = mn;
      e.mx  = mx;
      q.push_back(e);
   endtask

   task automatic send(input int v);
      sample_in    = DATA_W'(v);
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
   endtask

   task automatic send_n(input int v, input int n);
      for (int i = 0; i < n; i++) send(v);
   endtask

   // Monitor: every accepted result must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && avg_valid && avg_ready) begin
         if (q.size() == 0) begin
            check("unexpected_result", int'(avg_out), -1);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("avg_out", int'(avg_out), e.avg);
`ifdef ADC_AVG_MINMAX_EN
            check("min_out", int'(min_out), e.mn);
            check("max_out", int'(max_out), e.mx);
`endif
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_avg_out", int'(avg_out), 0);
      check("reset_avg_valid", int'(avg_valid), 0);
      check("reset_overrun", int'(overrun), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Constant window, single-cycle valid pulse.
      push(100, 100, 100);
      send_n(100, 8);
      check("pulse_valid_high", int'(avg_valid), 1);
      @(posedge clk);
      #1;
      check("pulse_valid_low", int'(avg_valid), 0);

      // Back-to-back windows: floor rounding, then full scale with no wrap.
      push(3, 0, 7);
      push(4095, 4095, 4095);
      for (int i = 0; i < 8; i++) send(i);
      send_n(4095, 8);
      @(posedge clk);
      #1;

      // Overwrite while downstream stalls.
      avg_ready = 1'b0;
      send_n(10, 8);
      check("ovr_first_valid", int'(avg_valid), 1);
      check("ovr_first_flag", int'(overrun), 0);
      send_n(20, 8);
      check("ovr_flag_set", int'(overrun), 1);
      check("ovr_avg_replaced", int'(avg_out), 20);
      clr_overrun = 1'b1;
      @(posedge clk);
      #1;
      clr_overrun = 1'b0;
      check("ovr_cleared", int'(overrun), 0);
      check("ovr_valid_held", int'(avg_valid), 1);
      push(20, 20, 20);
      avg_ready = 1'b1;
      @(posedge clk);
      #1;
      avg_ready = 1'b0;
      check("ovr_consumed", int'(avg_valid), 0);

      // Overrun set coinciding with clr_overrun: set wins.
      send_n(30, 8);
      check("held_avg", int'(avg_out), 30);
      check("no_ovr_after_consume", int'(overrun), 0);
      send_n(40, 7);
      clr_overrun = 1'b1;
      send(40);
      clr_overrun = 1'b0;
      check("set_wins_overrun", int'(overrun), 1);
      check("set_wins_avg", int'(avg_out), 40);

      // Async reset mid-window clears outputs and the partial sum.
      send_n(1000, 3);
      #3;
      rst = 1'b1;
      #1;
      check("rst_async_avg_out", int'(avg_out), 0);
      check("rst_async_avg_valid", int'(avg_valid), 0);
      check("rst_async_overrun", int'(overrun), 0);
`ifdef ADC_AVG_MINMAX_EN
      check("rst_async_min_out", int'(min_out), 0);
      check("rst_async_max_out", int'(max_out), 0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      avg_ready = 1'b1;
      push(7, 7, 7);
      send_n(7, 8);
      @(posedge clk);
      #1;

      // flush drops the partial window and a coincident sample.
      send_n(900, 5);
      flush = 1'b1;
      send(900);
      flush = 1'b0;
      push(50, 50, 50);
      send_n(50, 8);
      @(posedge clk);
      #1;

`ifdef ADC_AVG_MINMAX_EN
      push(4, 1, 12);
      send(5); send(9); send(1); send(12);
      send_n(3, 4);
      @(posedge clk);
      #1;
`endif

      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
      #1;
      check("scoreboard_drained", int'(q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
